// File: rtl/vin_freq_counter_if.sv
// Pin-side bundle for the VIN frequency counter: raw pin and enable in,
// windowed edge count with its strobe and overflow flag out.
interface vin_freq_counter_if #(
    parameter int WIDTH = 16
);
    logic             vin;
    logic             enable;
    logic [WIDTH-1:0] freq;
    logic             valid;
    logic             overflow;

    modport master (
        output vin,
        output enable,
        input  freq,
        input  valid,
        input  overflow
    );

    modport slave (
        input  vin,
        input  enable,
        output freq,
        output valid,
        output overflow
    );
endinterface

// File: rtl/vin_freq_counter.sv
// VIN frequency front end: two-flop synchroniser, stability glitch filter,
// saturating rising-edge counter and a fixed gate window publishing one count per window.
module vin_freq_counter #(
    parameter int GATE_CYCLES = 480000,
    parameter int FILTER_LEN  = 3,
    parameter int WIDTH       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    vin_freq_counter_if.slave  bus
);

    localparam int GCNT_W = $clog2(GATE_CYCLES);
    localparam int STAB_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GATE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);
    localparam logic [WIDTH-1:0]  ECNT_MAX  = '1;

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              filt_q, filt_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [WIDTH-1:0]  ecnt_q, ecnt_d;
    logic              sat_q, sat_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [WIDTH-1:0]  freq_q, freq_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;

    logic              rise;
    logic              sat_now;
    logic [WIDTH-1:0]  ecnt_next;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        s1_d       = bus.vin;
        s2_d       = s1_q;
        filt_d     = filt_q;
        stab_d     = '0;
        rise       = 1'b0;
        gcnt_d     = '0;
        ecnt_d     = '0;
        sat_d      = 1'b0;
        valid_d    = 1'b0;
        freq_d     = freq_q;
        overflow_d = overflow_q;

        // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
        if (s2_q != filt_q) begin
            if (stab_q == STAB_LAST) begin
                filt_d = s2_q;
                rise   = s2_q;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end

        sat_now   = rise && (ecnt_q == ECNT_MAX);
        ecnt_next = (rise && !sat_now) ? ecnt_q + WIDTH'(1) : ecnt_q;

        // An edge landing on the terminal cycle still belongs to the closing window.
        if (bus.enable) begin
            if (gcnt_q == GCNT_LAST) begin
                freq_d     = ecnt_next;
                overflow_d = sat_q | sat_now;
                valid_d    = 1'b1;
            end else begin
                gcnt_d = gcnt_q + GCNT_W'(1);
                ecnt_d = ecnt_next;
                sat_d  = sat_q | sat_now;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            filt_q     <= 1'b0;
            stab_q     <= '0;
            ecnt_q     <= '0;
            sat_q      <= 1'b0;
            gcnt_q     <= '0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            filt_q     <= filt_d;
            stab_q     <= stab_d;
            ecnt_q     <= ecnt_d;
            sat_q      <= sat_d;
            gcnt_q     <= gcnt_d;
            freq_q     <= freq_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.freq     = freq_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_vin_freq_counter.sv
// Directed bench for vin_freq_counter: a 16-bit FILTER_LEN=3 instance and a 4-bit
// FILTER_LEN=1 instance share the same pin/enable stimulus, GATE_CYCLES=100.
module tb_vin_freq_counter;

    logic clk;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    vin_freq_counter_if #(.WIDTH(16)) bus ();
    vin_freq_counter_if #(.WIDTH(4))  bus4 ();

    vin_freq_counter #(.GATE_CYCLES(100), .FILTER_LEN(3), .WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vin_freq_counter #(.GATE_CYCLES(100), .FILTER_LEN(1), .WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply pin/enable at a falling edge, let one rising edge consume them, return at the next falling edge.
    task automatic step(input logic v, input logic en);
        bus.vin     = v;
        bus.enable  = en;
        bus4.vin    = v;
        bus4.enable = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.vin = 1'b0;  bus.enable = 1'b0;
        bus4.vin = 1'b0; bus4.enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic sq10(input int i);
        return (i % 10) < 5;
    endfunction

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.freq, bus.valid, bus.overflow} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_async: got freq=%0d valid=%b ovf=%b want 0/0/0", bus.freq, bus.valid, bus.overflow);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) step(i[0], 1'b1);
        n_cmp++;
        if ({bus.freq, bus.valid, bus.overflow} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_held: got freq=%0d valid=%b ovf=%b want 0/0/0", bus.freq, bus.valid, bus.overflow);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step((i % 2) == 0, 1'b0);
        n_cmp++;
        if ({bus.freq, bus.valid, bus.overflow} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_idle: got freq=%0d valid=%b ovf=%b want 0/0/0", bus.freq, bus.valid, bus.overflow);
        end
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            step(sq10(i), 1'b1);
            if (bus.valid !== 1'b0 || bus.freq !== 16'd0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_first_window_quiet: got %0d bad cycles want 0", bad);
        end
        step(sq10(99), 1'b1);
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.freq !== 16'd10) begin
            n_err++;
            $display("FAIL reset_first_valid: got valid=%b freq=%0d want 1/10", bus.valid, bus.freq);
        end
    endtask

    task automatic test_square();
        int extra;
        do_reset();
        extra = 0;
        for (int i = 0; i < 300; i++) begin
            step(sq10(i), 1'b1);
            if ((i % 100) == 99) begin
                n_cmp++;
                if (bus.valid !== 1'b1 || bus.freq !== 16'd10 || bus.overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL square_win%0d: got valid=%b freq=%0d ovf=%b want 1/10/0", i / 100, bus.valid, bus.freq, bus.overflow);
                end
            end else if (bus.valid !== 1'b0) begin
                extra++;
            end
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL square_valid_spacing: got %0d stray valid cycles want 0", extra);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step((i % 10) < 2, 1'b1);
            if ((i % 100) == 99) begin
                n_cmp++;
                if (bus.valid !== 1'b1 || bus.freq !== 16'd0) begin
                    n_err++;
                    $display("FAIL glitch_win%0d: got valid=%b freq=%0d want 1/0", i / 100, bus.valid, bus.freq);
                end
            end
        end
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_cmp++;
        if (dut.filt_q !== 1'b0) begin
            n_err++;
            $display("FAIL filt_after_edge3: got %b want 0", dut.filt_q);
        end
        step(1'b0, 1'b0);
        n_cmp++;
        if (dut.filt_q !== 1'b1) begin
            n_err++;
            $display("FAIL filt_after_edge4: got %b want 1", dut.filt_q);
        end
    endtask

    task automatic test_saturation();
        logic v;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i < 100)      v = (i % 5) < 2;
            else if (i < 200) v = ((i - 100) % 20) < 10;
            else              v = ((i - 200) < 90) && (((i - 200) % 6) < 3);
            step(v, 1'b1);
            if (i == 99) begin
                n_cmp++;
                if (bus4.valid !== 1'b1 || bus4.freq !== 4'd15 || bus4.overflow !== 1'b1) begin
                    n_err++;
                    $display("FAIL sat_w4_win0: got valid=%b freq=%0d ovf=%b want 1/15/1", bus4.valid, bus4.freq, bus4.overflow);
                end
                n_cmp++;
                if (bus.freq !== 16'd0 || bus.overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL sat_w16_win0: got freq=%0d ovf=%b want 0/0", bus.freq, bus.overflow);
                end
            end
            if (i == 199) begin
                n_cmp++;
                if (bus4.valid !== 1'b1 || bus4.freq !== 4'd5 || bus4.overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL sat_w4_win1: got valid=%b freq=%0d ovf=%b want 1/5/0", bus4.valid, bus4.freq, bus4.overflow);
                end
                n_cmp++;
                if (bus.freq !== 16'd5) begin
                    n_err++;
                    $display("FAIL sat_w16_win1: got freq=%0d want 5", bus.freq);
                end
            end
            if (i == 299) begin
                n_cmp++;
                if (bus4.valid !== 1'b1 || bus4.freq !== 4'd15 || bus4.overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL sat_w4_exact_max: got valid=%b freq=%0d ovf=%b want 1/15/0", bus4.valid, bus4.freq, bus4.overflow);
                end
                n_cmp++;
                if (bus.freq !== 16'd15) begin
                    n_err++;
                    $display("FAIL sat_w16_win2: got freq=%0d want 15", bus.freq);
                end
            end
        end
    endtask

    task automatic test_enable_gap();
        int  bad;
        logic v;
        do_reset();
        bad = 0;
        for (int i = 0; i < 280; i++) begin
            v = (i < 180) ? sq10(i) : (((i - 180) % 20) < 10);
            step(v, !(i >= 150 && i < 180));
            if (i == 99) begin
                n_cmp++;
                if (bus.valid !== 1'b1 || bus.freq !== 16'd10) begin
                    n_err++;
                    $display("FAIL gap_first_window: got valid=%b freq=%0d want 1/10", bus.valid, bus.freq);
                end
            end
            if (i >= 100 && i < 279 && bus.valid !== 1'b0) bad++;
            if (i == 179) begin
                n_cmp++;
                if (bus.freq !== 16'd10) begin
                    n_err++;
                    $display("FAIL gap_freq_hold: got freq=%0d want 10", bus.freq);
                end
            end
            if (i == 279) begin
                n_cmp++;
                if (bus.valid !== 1'b1 || bus.freq !== 16'd5) begin
                    n_err++;
                    $display("FAIL gap_reenable_window: got valid=%b freq=%0d want 1/5", bus.valid, bus.freq);
                end
            end
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL gap_no_valid: got %0d valid cycles want 0", bad);
        end
    endtask

    task automatic test_terminal_edge();
        logic v;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            v = (i >= 10 && i < 20) || (i >= 30 && i < 40) || (i >= 95 && i <= 110);
            step(v, 1'b1);
            if (i == 99) begin
                n_cmp++;
                if (bus.valid !== 1'b1 || bus.freq !== 16'd3) begin
                    n_err++;
                    $display("FAIL term_closing_window: got valid=%b freq=%0d want 1/3", bus.valid, bus.freq);
                end
            end
            if (i == 199) begin
                n_cmp++;
                if (bus.valid !== 1'b1 || bus.freq !== 16'd0) begin
                    n_err++;
                    $display("FAIL term_next_window: got valid=%b freq=%0d want 1/0", bus.valid, bus.freq);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int bad;
        do_reset();
        for (int i = 0; i < 150; i++) step((i % 5) < 2, 1'b1);
        n_cmp++;
        if (bus4.freq !== 4'd15 || bus4.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: got freq=%0d ovf=%b want 15/1", bus4.freq, bus4.overflow);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus4.freq, bus4.valid, bus4.overflow} !== 6'd0) begin
            n_err++;
            $display("FAIL areset_immediate: got freq=%0d valid=%b ovf=%b want 0/0/0", bus4.freq, bus4.valid, bus4.overflow);
        end
        @(negedge clk);
        bad = 0;
        for (int i = 150; i < 210; i++) begin
            step((i % 5) < 2, 1'b1);
            if (bus4.valid !== 1'b0 || bus.valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL areset_no_valid: got %0d valid cycles want 0", bad);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.vin = 1'b0;  bus.enable = 1'b0;
        bus4.vin = 1'b0; bus4.enable = 1'b0;
        @(negedge clk);
        test_reset();
        test_square();
        test_glitch();
        test_saturation();
        test_enable_gap();
        test_terminal_edge();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
